// File: rtl/mrr_log2_compress_if.sv
// Handshake bundle for mrr_log2_compress: magnitude request on one side,
// floor(log2)/exact/zero result on the other.
// The ceil_out signal exists only when MRR_LOG2_CEIL_EN is defined.
interface mrr_log2_compress_if #(
    parameter int LOG2_WIDTH = 4
);
    localparam int W = (1 << LOG2_WIDTH) + 1;
    localparam int R = LOG2_WIDTH + 1;

    logic [W-1:0] num_in;
    logic         in_valid;
    logic         in_ready;
    logic [R-1:0] log2_out;
    logic         exact_out;
    logic         zero_out;
`ifdef MRR_LOG2_CEIL_EN
    logic [R-1:0] ceil_out;
`endif
    logic         out_valid;
    logic         out_ready;

`ifdef MRR_LOG2_CEIL_EN
    modport master (
        output num_in, in_valid, out_ready,
        input  in_ready, log2_out, exact_out, zero_out, ceil_out, out_valid
    );

    modport slave (
        input  num_in, in_valid, out_ready,
        output in_ready, log2_out, exact_out, zero_out, ceil_out, out_valid
    );
`else
    modport master (
        output num_in, in_valid, out_ready,
        input  in_ready, log2_out, exact_out, zero_out, out_valid
    );

    modport slave (
        input  num_in, in_valid, out_ready,
        output in_ready, log2_out, exact_out, zero_out, out_valid
    );
`endif
endinterface

// File: rtl/mrr_log2_compress.sv
// mrr_log2_compress: iterative binary-search encoder returning floor(log2)
// of a (2**LOG2_WIDTH+1)-bit magnitude, plus power-of-two and zero flags.
// One search step per cycle, LOG2_WIDTH+1 steps, so latency is constant.
// Optional feature: define MRR_LOG2_CEIL_EN to add the ceil(log2) output.
module mrr_log2_compress #(
    parameter int LOG2_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mrr_log2_compress_if.slave    bus
);
    localparam int W = (1 << LOG2_WIDTH) + 1;
    localparam int R = LOG2_WIDTH + 1;
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic [R-1:0] ONE_R = {{(R-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] work_q, work_d;
    logic [R-1:0] acc_q, acc_d;
    logic [R-1:0] step_q, step_d;
    logic         zero_q, zero_d;
    logic         exact_q, exact_d;
    logic [R-1:0] log2_out_q, log2_out_d;
    logic         exact_out_q, exact_out_d;
    logic         zero_out_q, zero_out_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
`ifdef MRR_LOG2_CEIL_EN
    logic [R-1:0] ceil_out_q, ceil_out_d;
`endif

    logic [R-1:0] shift_amt;
    logic [W-1:0] shifted;
    logic [R-1:0] acc_sum;

    // Next-state logic: accept in IDLE, halve the search window each SEARCH
    // cycle, and hold the registered result in DONE until it is taken.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        acc_d       = acc_q;
        step_d      = step_q;
        zero_d      = zero_q;
        exact_d     = exact_q;
        log2_out_d  = log2_out_q;
        exact_out_d = exact_out_q;
        zero_out_d  = zero_out_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef MRR_LOG2_CEIL_EN
        ceil_out_d  = ceil_out_q;
`endif
        shift_amt   = ONE_R << step_q;
        shifted     = work_q >> shift_amt;
        acc_sum     = acc_q + shift_amt;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d     = bus.num_in;
                    acc_d      = '0;
                    step_d     = R'(LOG2_WIDTH);
                    zero_d     = (bus.num_in == '0);
                    exact_d    = (bus.num_in != '0) &&
                                 ((bus.num_in & (bus.num_in - ONE_W)) == '0);
                    state_d    = SEARCH;
                    in_ready_d = 1'b0;
                end
            end
            SEARCH: begin
                if (shifted != '0) begin
                    work_d = shifted;
                    acc_d  = acc_sum;
                end
                if (step_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    log2_out_d  = acc_d;
                    exact_out_d = exact_q;
                    zero_out_d  = zero_q;
`ifdef MRR_LOG2_CEIL_EN
                    ceil_out_d  = acc_d + {{(R-1){1'b0}}, (~exact_q & ~zero_q)};
`endif
                end else begin
                    step_d = step_q - ONE_R;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and result registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            zero_q      <= 1'b0;
            exact_q     <= 1'b0;
            log2_out_q  <= '0;
            exact_out_q <= 1'b0;
            zero_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef MRR_LOG2_CEIL_EN
            ceil_out_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            zero_q      <= zero_d;
            exact_q     <= exact_d;
            log2_out_q  <= log2_out_d;
            exact_out_q <= exact_out_d;
            zero_out_q  <= zero_out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef MRR_LOG2_CEIL_EN
            ceil_out_q  <= ceil_out_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.log2_out  = log2_out_q;
    assign bus.exact_out = exact_out_q;
    assign bus.zero_out  = zero_out_q;
`ifdef MRR_LOG2_CEIL_EN
    assign bus.ceil_out  = ceil_out_q;
`endif
endmodule

// File: tb/tb_mrr_log2_compress.sv
// Testbench for mrr_log2_compress: directed vectors with hand-computed
// results, a scoreboard queue filled by the driver and drained by a monitor.
module tb_mrr_log2_compress;
    localparam int LOG2_WIDTH = 4;
    localparam int W = (1 << LOG2_WIDTH) + 1;
    localparam int R = LOG2_WIDTH + 1;
    localparam int LATENCY = LOG2_WIDTH + 1;

    typedef struct {
        int log2;
        int exact;
        int zero;
        int ceil;
        int accept;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cycle_count;
    logic prev_valid;
    exp_t sb_q[$];

    mrr_log2_compress_if #(.LOG2_WIDTH(LOG2_WIDTH)) bus ();

    mrr_log2_compress #(.LOG2_WIDTH(LOG2_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle_count);
        end
    endtask

    // Drive one request and push its expected result once it is accepted.
    task automatic applyStimulus(input logic [W-1:0] value, input int e_log2, input int e_exact,
                                 input int e_zero, input int e_ceil, input bit keep_valid,
                                 output int accept_cycle);
        exp_t e;
        int   waited;
        bus.num_in   = value;
        bus.in_valid = 1'b1;
        waited       = 0;
        accept_cycle = -1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end else begin
            e.log2       = e_log2;
            e.exact      = e_exact;
            e.zero       = e_zero;
            e.ceil       = e_ceil;
            e.accept     = cycle_count + 1;
            accept_cycle = e.accept;
            sb_q.push_back(e);
            @(negedge clk);
            if (!keep_valid) bus.in_valid = 1'b0;
        end
    endtask

    // Monitor: check latency on the rising edge of out_valid and compare
    // the result against the scoreboard on every completed handshake.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid && sb_q.size() > 0)
                checkOutput("latency", cycle_count - sb_q[0].accept, LATENCY);
            prev_valid = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("log2_out", int'(bus.log2_out), e.log2);
                    checkOutput("exact_out", int'(bus.exact_out), e.exact);
                    checkOutput("zero_out", int'(bus.zero_out), e.zero);
`ifdef MRR_LOG2_CEIL_EN
                    checkOutput("ceil_out", int'(bus.ceil_out), e.ceil);
`endif
                end
            end
        end
    end

    initial begin
        int acc_cyc;
        int last_acc;
        int waited;
        logic [W-1:0] pow;
        checks       = 0;
        errors       = 0;
        cycle_count  = 0;
        prev_valid   = 1'b0;
        reset        = 1'b1;
        bus.num_in   = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_log2_out", int'(bus.log2_out), 0);
        checkOutput("rst_exact_out", int'(bus.exact_out), 0);
        checkOutput("rst_zero_out", int'(bus.zero_out), 0);
`ifdef MRR_LOG2_CEIL_EN
        checkOutput("rst_ceil_out", int'(bus.ceil_out), 0);
`endif

        $display("[TB] directed vectors");
        applyStimulus(17'h00400, 10, 1, 0, 10, 1'b0, acc_cyc);
        applyStimulus(17'h00000,  0, 0, 1,  0, 1'b0, acc_cyc);
        applyStimulus(17'h1FFFF, 16, 0, 0, 17, 1'b0, acc_cyc);
        applyStimulus(17'h00003,  1, 0, 0,  2, 1'b0, acc_cyc);
        applyStimulus(17'h00001,  0, 1, 0,  0, 1'b0, acc_cyc);
        applyStimulus(17'h10000, 16, 1, 0, 16, 1'b0, acc_cyc);
        applyStimulus(17'h00005,  2, 0, 0,  3, 1'b0, acc_cyc);
        applyStimulus(17'h0FFFF, 15, 0, 0, 16, 1'b0, acc_cyc);

        $display("[TB] backpressure in DONE");
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        bus.out_ready = 1'b0;
        applyStimulus(17'h00100, 8, 1, 0, 8, 1'b0, acc_cyc);
        waited = 0;
        while (!bus.out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("stall_reach_done", int'(bus.out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.num_in   = 17'h00005;
            @(negedge clk);
            checkOutput("stall_out_valid", int'(bus.out_valid), 1);
            checkOutput("stall_in_ready", int'(bus.in_ready), 0);
            checkOutput("stall_log2_out", int'(bus.log2_out), 8);
            checkOutput("stall_exact_out", int'(bus.exact_out), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("release_in_ready", int'(bus.in_ready), 1);
        checkOutput("release_out_valid", int'(bus.out_valid), 0);

        $display("[TB] reset during SEARCH");
        bus.num_in   = 17'h00040;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_in_ready", int'(bus.in_ready), 1);
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        repeat (8) @(negedge clk);
        checkOutput("abort_no_result", int'(bus.out_valid), 0);
        applyStimulus(17'h00008, 3, 1, 0, 3, 1'b0, acc_cyc);

        $display("[TB] round trip 1<<k back-to-back");
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        last_acc = -1;
        for (int k = 0; k <= 16; k++) begin
            pow = '0;
            pow[k] = 1'b1;
            applyStimulus(pow, k, 1, 0, k, (k != 16), acc_cyc);
            if (k > 0) checkOutput("rt_period", acc_cyc - last_acc, LOG2_WIDTH + 3);
            last_acc = acc_cyc;
        end

        waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
